// File: rtl/comparador_pkg.sv
// Shared types and helpers for the bit-serial A>B comparator.
package comparador_pkg;

    // Two-bit encoding picked so busy and done are each a single state bit.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Bit-position counter width, never narrower than one bit (covers K=1).
    function automatic int idx_width(input int k);
        if ($clog2(k) < 1) return 1;
        return $clog2(k);
    endfunction

endpackage

// File: rtl/celda_serial.sv
// Single right-to-left A>B comparison cell, purely combinational.
// n_out is 1 when this bit already decides a > b, or when the bits are equal
// and the lower-order result was already a > b.
module celda_serial (
    input  logic n_in,
    input  logic a,
    input  logic b,
    output logic n_out
);

    assign n_out = (a & ~b) | (~(a ^ b) & n_in);

endmodule

// File: rtl/comparador_serial.sv
// Bit-serial A>B comparator: one shared cell walks the K bit positions LSB
// first, one per clock, then presents Z and the per-stage trace N.
// Optional build macro: CMP_TRACE_EN builds the K-bit N trace register;
// without it N is tied to zero.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// RUN   | one bit position evaluated per clock, idx = 0 .. K-1
// DONE  | one-cycle result strobe, returns to IDLE unconditionally
module comparador_serial
    import comparador_pkg::*;
#(
    parameter int K = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [K-1:0] A,
    input  logic [K-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [K-1:0] N,
    output logic         Z
);

    localparam int            IW   = idx_width(K);
    localparam logic [IW-1:0] LAST = IW'(K - 1);

    state_t         state_q, state_d;
    logic [K-1:0]   a_sh_q, a_sh_d;
    logic [K-1:0]   b_sh_q, b_sh_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           n_q, n_d;
    logic           z_q, z_d;
    logic           n_cell;

    celda_serial u_celda (
        .n_in  (n_q),
        .a     (a_sh_q[0]),
        .b     (b_sh_q[0]),
        .n_out (n_cell)
    );

    // Next-state and datapath update: capture in IDLE, shift and accumulate in RUN.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        idx_d   = idx_q;
        n_d     = n_q;
        z_d     = z_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = A;
                    b_sh_d  = B;
                    n_d     = 1'b0;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                n_d    = n_cell;
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                idx_d  = idx_q + IW'(1);
                if (idx_q == LAST) begin
                    z_d     = n_cell;
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control and datapath registers; reset abandons any comparison in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            idx_q   <= '0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            z_q     <= z_d;
        end
    end

`ifdef CMP_TRACE_EN
    logic [K-1:0] n_vec_q, n_vec_d;

    // Trace update: cleared on acceptance, stage idx written on each RUN edge.
    always_comb begin
        n_vec_d = n_vec_q;
        if (state_q == IDLE && start) begin
            n_vec_d = '0;
        end else if (state_q == RUN) begin
            for (int i = 0; i < K; i++) begin
                if (idx_q == IW'(i)) n_vec_d[i] = n_cell;
            end
        end
    end

    // Trace register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) n_vec_q <= '0;
        else        n_vec_q <= n_vec_d;
    end

    assign N = n_vec_q;
`else
    assign N = '0;
`endif

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign Z    = z_q;

endmodule

// File: tb/tb_comparador_serial.sv
// Scoreboard bench for comparador_serial: a K=5 instance and a K=1 instance.
// Expected results are queued when an operation is launched; monitors pop and
// compare whenever a done pulse appears.
module tb_comparador_serial;

    localparam int K = 5;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [K-1:0] a, b;
    logic         busy, done, z;
    logic [K-1:0] n;

    logic         start1;
    logic [0:0]   a1, b1;
    logic         busy1, done1, z1;
    logic [0:0]   n1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic         z;
        logic [K-1:0] n;
        string        tag;
    } exp_t;

    exp_t q5[$];
    exp_t q1[$];
    exp_t e5, e1;

    comparador_serial #(.K(K)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(a), .B(b),
        .busy(busy), .done(done), .N(n), .Z(z)
    );

    comparador_serial #(.K(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .A(a1), .B(b1),
        .busy(busy1), .done(done1), .N(n1), .Z(z1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [K-1:0] tr(input logic [K-1:0] v);
`ifdef CMP_TRACE_EN
        return v;
`else
        return '0;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // K=5 monitor
    always @(negedge clk) begin
        if (rst_n && done === 1'b1) begin
            if (q5.size() == 0) begin
                check("k5 unexpected done", 1, 0);
            end else begin
                e5 = q5.pop_front();
                check({e5.tag, " Z"}, 32'(z), 32'(e5.z));
                check({e5.tag, " N"}, 32'(n), 32'(tr(e5.n)));
            end
        end
    end

    // K=1 monitor
    always @(negedge clk) begin
        if (rst_n && done1 === 1'b1) begin
            if (q1.size() == 0) begin
                check("k1 unexpected done", 1, 0);
            end else begin
                e1 = q1.pop_front();
                check({e1.tag, " Z"}, 32'(z1), 32'(e1.z));
                check({e1.tag, " N"}, 32'(n1), 32'(tr(e1.n) & 5'b00001));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one K=5 operation, scramble the operand inputs after capture,
    // then check busy width, done position and done width.
    task automatic run5(input logic [K-1:0] av, input logic [K-1:0] bv,
                        input logic ez, input logic [K-1:0] en, input string tag);
        int busy_cnt = 0;
        int done_at  = -1;
        a = av; b = bv; start = 1'b1;
        q5.push_back('{z: ez, n: en, tag: tag});
        tick();
        start = 1'b0;
        a = ~av; b = ~bv;
        for (int i = 0; i < K + 6; i++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_at = i;
                break;
            end
            tick();
        end
        check({tag, " busy cycles"}, busy_cnt, K);
        check({tag, " done position"}, done_at, K);
        tick();
        check({tag, " done width"}, {30'd0, busy, done}, 0);
    endtask

    task automatic run1(input logic av, input logic bv, input logic ez, input string tag);
        int done_at = -1;
        a1 = av; b1 = bv; start1 = 1'b1;
        q1.push_back('{z: ez, n: K'(ez), tag: tag});
        tick();
        start1 = 1'b0;
        a1 = ~av; b1 = ~bv;
        for (int i = 0; i < 6; i++) begin
            if (done1) begin
                done_at = i;
                break;
            end
            tick();
        end
        check({tag, " done position"}, done_at, 1);
        tick();
    endtask

    initial begin
        int rise_at;
        int done_seen;
        logic prev_busy;

        start = 0; a = '0; b = '0;
        start1 = 0; a1 = '0; b1 = '0;
        rst_n = 1'b0;
        #1;
        check("reset outputs k5", {busy, done, z, n}, 0);
        check("reset outputs k1", {busy1, done1, z1, n1}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();

        run5(5'd22, 5'd21, 1'b1, 5'b11110, "22>21");
        run5(5'd16, 5'd15, 1'b1, 5'b10000, "16>15");
        run5(5'd13, 5'd13, 1'b0, 5'b00000, "13=13");
        run5(5'd0,  5'd31, 1'b0, 5'b00000, "0<31");
        run5(5'd5,  5'd6,  1'b0, 5'b00001, "5<6");
        run5(5'd31, 5'd0,  1'b1, 5'b11111, "31>0");

        // start during RUN is ignored; start held re-launches after DONE
        a = 5'd22; b = 5'd21; start = 1'b1;
        q5.push_back('{z: 1'b1, n: 5'b11110, tag: "first of pair"});
        tick();
        start = 1'b0;
        a = 5'd0; b = 5'd31;
        prev_busy = busy;
        rise_at = -1;
        for (int i = 1; i < 20; i++) begin
            tick();
            if (!prev_busy && busy) begin
                rise_at = i;
                break;
            end
            prev_busy = busy;
            if (i == 2) start = 1'b1;
        end
        check("held start spacing", rise_at, K + 2);
        q5.push_back('{z: 1'b0, n: 5'b00000, tag: "relaunch 0<31"});
        start = 1'b0;
        done_seen = 0;
        for (int i = 0; i < K + 4; i++) begin
            if (done) begin
                done_seen = 1;
                break;
            end
            tick();
        end
        check("relaunch done seen", done_seen, 1);
        tick();

        // reset in the middle of RUN
        a = 5'd22; b = 5'd21; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midrun reset outputs", {busy, done, z, n}, 0);
        q5.delete();
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < K + 3; i++) begin
            tick();
            if (done) done_seen++;
        end
        check("no done after reset", done_seen, 0);
        run5(5'd22, 5'd21, 1'b1, 5'b11110, "after reset 22>21");

        // K=1 instance
        run1(1'b1, 1'b0, 1'b1, "k1 1>0");
        run1(1'b1, 1'b1, 1'b0, "k1 1=1");
        run1(1'b0, 1'b1, 1'b0, "k1 0<1");

        repeat (4) tick();
        check("k5 queue drained", q5.size(), 0);
        check("k1 queue drained", q1.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
